// File: rtl/axilite_arb.sv
// Round-robin arbiter sharing one AXI-Lite control master among NREQ requesters.
// One transaction outstanding at a time; timeouts complete with an error and drain the late done.
module axilite_arb #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_aresetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  input  logic [4*NREQ-1:0]    req_wstrb,
  output logic [NREQ-1:0]      req_ack,
  output logic                 rsp_err,
  output logic [31:0]          rsp_rdata,
  output logic                 busy,
  output logic                 start_write,
  output logic                 start_read,
  output logic [31:0]          write_addr,
  output logic [31:0]          write_data,
  output logic [3:0]           write_strb,
  output logic [31:0]          read_addr,
  input  logic [31:0]          read_data,
  input  logic                 done
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant, grant_nxt, last_grant, last_grant_nxt;
  logic [TW-1:0]     timer, timer_nxt;
  logic              drain, drain_nxt, is_write, is_write_nxt;
  logic [NREQ-1:0]   ack_nxt;
  logic              err_nxt, busy_nxt, start_w_nxt, start_r_nxt;
  logic [31:0]       rdata_nxt, waddr_nxt, wdata_nxt, raddr_nxt;
  logic [3:0]        wstrb_nxt;

  logic [2*NREQ-1:0] rot;
  int                first, pick;
  logic              sel_write;
  logic [31:0]       sel_addr, sel_wdata;
  logic [3:0]        sel_wstrb;

  // Round-robin pick: rotate so bit k is requester (last_grant+1+k) mod NREQ
  always_comb begin
    rot       = {req_valid, req_valid} >> (32'(last_grant) + 32'd1);
    first     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) first = k;
    end
    pick = 32'(last_grant) + 1 + first;
    if (pick >= NREQ) pick = pick - NREQ;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == i) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
        sel_wstrb = req_wstrb[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    drain_nxt      = drain;
    is_write_nxt   = is_write;
    ack_nxt        = '0;
    err_nxt        = 1'b0;
    rdata_nxt      = '0;
    start_w_nxt    = 1'b0;
    start_r_nxt    = 1'b0;
    waddr_nxt      = write_addr;
    wdata_nxt      = write_data;
    wstrb_nxt      = write_strb;
    raddr_nxt      = read_addr;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt    = pick[GW-1:0];
          is_write_nxt = sel_write;
          if (sel_write) begin
            waddr_nxt   = sel_addr;
            wdata_nxt   = sel_wdata;
            wstrb_nxt   = sel_wstrb;
            start_w_nxt = 1'b1;
          end else begin
            raddr_nxt   = sel_addr;
            start_r_nxt = 1'b1;
          end
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + 1'b1;
        // Timeout fires in the cycle the timer steps onto TIMEOUT-1; done in that same cycle wins
        if (done) begin
          state_nxt      = RESP;
          ack_nxt[grant] = 1'b1;
          rdata_nxt      = is_write ? 32'd0 : read_data;
          last_grant_nxt = grant;
        end else if (timer == TW'(TIMEOUT - 2)) begin
          state_nxt      = RESP;
          ack_nxt[grant] = 1'b1;
          err_nxt        = 1'b1;
          drain_nxt      = 1'b1;
          last_grant_nxt = grant;
        end
      end
      RESP: state_nxt = drain ? DRAIN : IDLE;
      DRAIN: begin
        if (done) begin
          drain_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= GW'(NREQ - 1);
      timer       <= '0;
      drain       <= 1'b0;
      is_write    <= 1'b0;
      req_ack     <= '0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
      start_write <= 1'b0;
      start_read  <= 1'b0;
      write_addr  <= '0;
      write_data  <= '0;
      write_strb  <= '0;
      read_addr   <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      last_grant  <= last_grant_nxt;
      timer       <= timer_nxt;
      drain       <= drain_nxt;
      is_write    <= is_write_nxt;
      req_ack     <= ack_nxt;
      rsp_err     <= err_nxt;
      rsp_rdata   <= rdata_nxt;
      busy        <= busy_nxt;
      start_write <= start_w_nxt;
      start_read  <= start_r_nxt;
      write_addr  <= waddr_nxt;
      write_data  <= wdata_nxt;
      write_strb  <= wstrb_nxt;
      read_addr   <= raddr_nxt;
    end
  end

endmodule

// File: tb/tb_axilite_arb.sv
// Randomized bench for axilite_arb: requesters and master are modelled here,
// grants/responses predicted from round-robin and timeout rules.
module tb_axilite_arb;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 16;

  logic                m_axi_aclk = 1'b0;
  logic                m_axi_aresetn = 1'b0;
  logic [NREQ-1:0]     req_valid, req_write;
  logic [32*NREQ-1:0]  req_addr, req_wdata;
  logic [4*NREQ-1:0]   req_wstrb;
  logic [NREQ-1:0]     req_ack;
  logic                rsp_err, busy, start_write, start_read, done;
  logic [31:0]         rsp_rdata, write_addr, write_data, read_addr, read_data;
  logic [3:0]          write_strb;

  always #5 m_axi_aclk = ~m_axi_aclk;

  axilite_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .m_axi_aclk(m_axi_aclk), .m_axi_aresetn(m_axi_aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ack(req_ack),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .start_write(start_write), .start_read(start_read),
    .write_addr(write_addr), .write_data(write_data), .write_strb(write_strb),
    .read_addr(read_addr), .read_data(read_data), .done(done)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [NREQ-1:0] pend;
  logic            rw [NREQ];
  logic [31:0]     ra [NREQ];
  logic [31:0]     rd [NREQ];
  logic [3:0]      rs [NREQ];
  int              last_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input logic [NREQ-1:0] p, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (p[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_write[i]          = rw[i];
      req_addr[32*i +: 32]  = ra[i];
      req_wdata[32*i +: 32] = rd[i];
      req_wstrb[4*i +: 4]   = rs[i];
    end
  endtask

  task automatic tick();
    @(posedge m_axi_aclk);
    #1;
  endtask

  task automatic new_req(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    rw[i] = w; ra[i] = a; rd[i] = d; rs[i] = s; pend[i] = 1'b1;
  endtask

  task automatic new_rand(input int i);
    new_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
  endtask

  // Called with the DUT in IDLE; dly = WAIT cycle index carrying done (beyond TIMEOUT-2 = never)
  task automatic do_txn(input int dly, input bit violate, input logic [31:0] rdat);
    int   g;
    bit   tmo;
    g = rr(pend, last_g);
    if (g < 0) return;
    tmo = (dly > TIMEOUT - 2);
    drive();
    tick();
    chk("start_write", 32'(start_write), 32'(rw[g]));
    chk("start_read", 32'(start_read), 32'(!rw[g]));
    if (rw[g]) begin
      chk("write_addr", write_addr, ra[g]);
      chk("write_data", write_data, rd[g]);
      chk("write_strb", 32'(write_strb), 32'(rs[g]));
    end else begin
      chk("read_addr", read_addr, ra[g]);
    end
    chk("busy_issue", 32'(busy), 32'd1);
    done = 1'($urandom_range(0, 1));
    read_data = $urandom;
    tick();
    done = 1'b0;
    chk("start_in_wait", 32'(start_write | start_read), 32'd0);
    for (int w = 0; w <= TIMEOUT - 2; w++) begin
      if (violate && w == 0) begin
        pend[g] = 1'b0;
        drive();
      end
      if (w == dly) begin
        done = 1'b1;
        read_data = rdat;
      end else begin
        read_data = $urandom;
      end
      tick();
      done = 1'b0;
      if (w == dly || w == TIMEOUT - 2) break;
      chk("ack_early", 32'(req_ack), 32'd0);
    end
    chk("ack", 32'(req_ack), 32'd1 << g);
    chk("rsp_err", 32'(rsp_err), 32'(tmo));
    chk("rsp_rdata", rsp_rdata, (tmo || rw[g]) ? 32'd0 : rdat);
    chk("busy_resp", 32'(busy), 32'd1);
    chk("addr_held", rw[g] ? write_addr : read_addr, ra[g]);
    last_g  = g;
    pend[g] = 1'b0;
    drive();
    tick();
    if (tmo) begin
      chk("busy_drain", 32'(busy), 32'd1);
      repeat ($urandom_range(1, 5)) begin
        tick();
        chk("drain_start", 32'(start_write | start_read), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_ack", 32'(req_ack), 32'd0);
      end
      done = 1'b1;
      read_data = $urandom;
      tick();
      done = 1'b0;
    end
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ack_idle", 32'(req_ack), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'({start_write, start_read}), 32'd0);
    chk({tag, "_waddr"}, write_addr, 32'd0);
    chk({tag, "_wdata"}, write_data, 32'd0);
    chk({tag, "_wstrb"}, 32'(write_strb), 32'd0);
    chk({tag, "_raddr"}, read_addr, 32'd0);
  endtask

  initial begin
    int dly;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin
      rw[i] = 1'b0; ra[i] = '0; rd[i] = '0; rs[i] = '0;
    end
    done = 1'b0;
    read_data = '0;
    drive();
    last_g = NREQ - 1;
    repeat (3) tick();
    chk_all_zero("reset");
    m_axi_aresetn = 1'b1;
    tick();

    done = 1'b1;
    tick();
    done = 1'b0;
    chk("idle_stray_done_busy", 32'(busy), 32'd0);
    chk("idle_stray_done_start", 32'(start_write | start_read), 32'd0);

    new_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_txn(3, 1'b0, 32'h0);
    new_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    do_txn(2, 1'b0, 32'h12345678);

    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) new_rand(0);
      if (!pend[1]) new_rand(1);
      do_txn($urandom_range(0, 6), 1'b0, $urandom);
    end

    new_rand(0);
    new_rand(1);
    do_txn(TIMEOUT + 5, 1'b0, $urandom);
    do_txn(1, 1'b0, $urandom);
    new_rand(2);
    do_txn(TIMEOUT - 2, 1'b0, $urandom);
    if (pend == '0) new_rand(0);
    do_txn(1, 1'b1, $urandom);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) new_rand(i);
      end
      if (pend == '0) new_rand($urandom_range(0, NREQ - 1));
      case ($urandom_range(0, 7))
        0:       dly = TIMEOUT + $urandom_range(0, 8);
        1:       dly = TIMEOUT - 2;
        default: dly = $urandom_range(0, 10);
      endcase
      do_txn(dly, $urandom_range(0, 9) == 0, $urandom);
    end

    new_rand(1);
    new_rand(2);
    drive();
    tick();
    tick();
    tick();
    #2;
    m_axi_aresetn = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    chk("reset_no_ack", 32'(req_ack), 32'd0);
    last_g = NREQ - 1;
    new_rand(0);
    m_axi_aresetn = 1'b1;
    do_txn(2, 1'b0, $urandom);
    do_txn(4, 1'b0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axilite_arb.md
AXILITE_ARB -- requirements
Module: axilite_arb

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters sharing one axilite_m control port (2..8).
REQ-002 Parameter: TIMEOUT, default 1024, max cycles in WAIT before error completion (>=2).
REQ-003 m_axi_aclk  in  1  clock; all logic rising-edge.
REQ-004 m_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NREQ  bit i: requester i transaction pending; held high until its ack.
REQ-006 req_write  in  NREQ  bit i: 1 = write, 0 = read.
REQ-007 req_addr  in  32*NREQ  slice [32i+31:32i] = address of requester i.
REQ-008 req_wdata  in  32*NREQ  slice i = write data.
REQ-009 req_wstrb  in  4*NREQ  slice i = write strobe.
REQ-010 req_ack  out  NREQ  one-hot, one-cycle completion pulse to granted requester.
REQ-011 rsp_err  out  1  1 = completion by timeout; valid only with req_ack.
REQ-012 rsp_rdata  out  32  read data; valid only with req_ack; 0 for writes and errors.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 start_write, start_read  out  1 each  to master; one-cycle start pulses.
REQ-015 write_addr, write_data, read_addr  out  32 each; write_strb  out  4  to master.
REQ-016 read_data  in  32; done  in  1  from master; done is a one-cycle completion pulse.

Function
REQ-017 States: IDLE, ISSUE, WAIT, RESP, DRAIN; all outputs registered.
REQ-018 IDLE: if any req_valid set, grant g = first set bit searching round-robin from last_grant+1 (mod NREQ); latch g; load write_* or read_addr from slice g; next state ISSUE; else stay.
REQ-019 ISSUE: start_write (req_write[g]=1) or start_read (0) high for exactly this one cycle; other start stays 0; timer cleared; next state WAIT.
REQ-020 Master address/data/strb outputs hold latched values from ISSUE until the next grant.
REQ-021 WAIT: timer increments each cycle; on done -> RESP with rsp_err=0, rsp_rdata = read_data for reads or 0 for writes; last_grant <= g.
REQ-022 WAIT: if timer reaches TIMEOUT-1 without done -> RESP with rsp_err=1, rsp_rdata=0, drain flag set; last_grant <= g.
REQ-023 done and timeout in the same cycle: done wins, rsp_err=0.
REQ-024 RESP: req_ack[g]=1 for this single cycle, rsp_err/rsp_rdata valid; req_valid ignored; next IDLE, or DRAIN if drain flag set.
REQ-025 Requesters deassert req_valid on the edge where req_ack is sampled high, so IDLE never re-grants a completed request.
REQ-026 DRAIN: no start issued; wait for done, discard read_data, clear drain flag, next IDLE; no ack generated.
REQ-027 done outside WAIT/DRAIN is ignored.
REQ-028 req_valid deasserted before ack (protocol violation) does not abort the transaction; ack is still issued.
REQ-029 Latency: request seen in IDLE at cycle 0 -> start pulse at cycle 1 -> ack one cycle after done sampled.
REQ-030 Only one transaction outstanding at the master at any time.

Reset
REQ-031 On m_axi_aresetn low: state IDLE; req_ack, rsp_err, rsp_rdata, busy, start_*, write_*, read_addr = 0; timer, drain flag = 0; last_grant = NREQ-1, so requester 0 wins first.
REQ-032 Reset mid-transaction aborts silently: no ack, no error pulse; the master is reset by the same signal.

Verification
REQ-033 r0 write addr 0x10 data 0xDEADBEEF strb 0xF -> start_write one cycle, write_addr 0x10, write_strb 0xF; req_ack=01 one cycle after done, rsp_err 0.
REQ-034 r1 read addr 0x20, master done with read_data 0x12345678 -> req_ack=10, rsp_rdata 0x12345678, start_write never high.
REQ-035 After reset, r0 and r1 valid together, repeated 4x -> grant order r0,r1,r0,r1; each ack one-hot.
REQ-036 TIMEOUT=16, done withheld -> ack with rsp_err=1, rsp_rdata 0, 16 cycles after the ISSUE cycle; busy stays high through DRAIN; no new start until done, then next requester served.
REQ-037 done coincident with timer = TIMEOUT-1 -> rsp_err 0, no DRAIN.
REQ-038 Reset asserted in WAIT -> all outputs 0 asynchronously, no ack; first post-reset grant goes to r0.
